watch_set_controller: RTL and testbench
=======================================

// Module: watch_set_controller
// PURPOSE
//  Mode/time-set sequencer driven by debounced push-button events (one-cycle
//  *_down pulses and *_state levels). Cycles the watch between RUN and three
//  set modes, and issues one-cycle adjust strobes to the timekeeping counters,
//  with hold-to-auto-repeat. Sits between the button debouncers and the
//  hour/minute/second counters and display blanking.
// PARAMETERS
//  CNT_W          14     width of all tick counters
//  HOLD_TICKS     500    ticks adj must be held before auto-repeat starts
//  REPEAT_TICKS   100    ticks between auto-repeat strobes
//  TIMEOUT_TICKS  10000  idle ticks in a set mode before forced return to RUN
//  BLINK_TICKS    250    ticks per blink half-period
//  Constraints: all *_TICKS >= 1 and < 2**CNT_W (elaboration error otherwise).
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  synchronous, active-low reset
//  tick       in   1  one-cycle timebase enable (e.g. 1 kHz); all timers count ticks
//  mode_down  in   1  debounced mode-button press pulse
//  adj_down   in   1  debounced adjust-button press pulse
//  adj_state  in   1  debounced adjust-button level (1 = held)
//  state_o    out  2  current mode: 0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_SEC
//  run_en     out  1  1 only in RUN; gates timekeeping counters
//  inc_hr     out  1  one-cycle hour increment strobe
//  inc_min    out  1  one-cycle minute increment strobe
//  clr_sec    out  1  one-cycle seconds clear strobe
//  blink      out  1  blanking phase for the field being set; 0 in RUN
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state RUN, run_en=1, all strobes 0, blink 0,
//    all counters 0. Applies mid-set or mid-repeat; no strobe emitted after it.
//  - All outputs registered. mode_down advances RUN->SET_HR->SET_MIN->SET_SEC->RUN;
//    state_o/run_en change the cycle after the pulse.
//  - In RUN, adj_down/adj_state are ignored; hold/idle/blink counters held at 0.
//  - In a set mode, adj_down yields one strobe the next cycle: inc_hr (SET_HR),
//    inc_min (SET_MIN), clr_sec (SET_SEC). At most one strobe high per cycle.
//  - Auto-repeat (SET_HR, SET_MIN only): hold counter counts ticks while
//    adj_state=1; on reaching HOLD_TICKS emit a strobe, then one strobe every
//    REPEAT_TICKS ticks while held. adj_state=0 clears hold and repeat counters.
//    SET_SEC never repeats.
//  - Simultaneous mode_down and adj_down: mode wins; adjust strobe suppressed;
//    hold/repeat counters cleared. Mode change while held: repeat restarts from
//    HOLD_TICKS only after adj_state drops and a new press occurs.
//  - Idle timeout: counts ticks in set modes; cleared by mode_down, adj_down, or
//    adj_state=1. Reaching TIMEOUT_TICKS -> RUN next cycle, no strobe.
//  - blink: on every state entry blink=0 and blink counter=0; toggles each
//    BLINK_TICKS ticks in set modes; forced 0 in RUN.
//  - Counters never wrap: compare-and-reload, saturate at 2**CNT_W-1.
//  - tick and a button event in the same cycle: both take effect that cycle.
// STRUCTURE
//  - Package watch_ctrl_pkg: mode encoding (RUN/SET_HR/SET_MIN/SET_SEC),
//    default tick constants, CNT_W default.
//  - Sub-module btn_autorepeat (clk, rst_n, tick, en, press, held -> strobe):
//    hold/repeat counter pair; instantiated once, en=(SET_HR|SET_MIN).
//  - Top holds mode FSM, idle timer, blink timer, strobe decode.
// TESTING (small params: HOLD=4, REPEAT=2, TIMEOUT=20, BLINK=3, tick every cycle)
//  1 Reset then 4 mode_down pulses -> state_o 1,2,3,0; run_en 0,0,0,1.
//  2 SET_HR, single adj_down, adj_state low -> exactly one inc_hr, next cycle.
//  3 SET_MIN, adj held 12 ticks -> inc_min at press+1, then at ticks 4,6,8,10,12.
//  4 SET_SEC, adj held 20 ticks -> exactly one clr_sec; no timeout while held.
//  5 SET_HR idle 20 ticks -> state_o 0 next cycle, no strobes; mode_down+adj_down
//    same cycle -> state advances, no strobe.
//  6 rst_n low mid auto-repeat in SET_MIN -> state 0, strobes 0, blink 0 next edge.

Source files
------------

// File: rtl/watch_ctrl_pkg.sv
// rtl/watch_ctrl_pkg.sv - mode encoding and default timing constants for the watch set controller
package watch_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } mode_e;

    localparam int CNT_W_DEF         = 14;
    localparam int HOLD_TICKS_DEF    = 500;
    localparam int REPEAT_TICKS_DEF  = 100;
    localparam int TIMEOUT_TICKS_DEF = 10000;
    localparam int BLINK_TICKS_DEF   = 250;

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            RUN:     return SET_HR;
            SET_HR:  return SET_MIN;
            SET_MIN: return SET_SEC;
            default: return RUN;
        endcase
    endfunction

endpackage

// File: rtl/btn_autorepeat.sv
// rtl/btn_autorepeat.sv - hold-then-repeat strobe generator for the adjust button
module btn_autorepeat #(
    parameter int CNT_W        = 14,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic en,
    input  logic press,
    input  logic held,
    output logic strobe
);
    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_TICKS);
    localparam logic [CNT_W-1:0] REP_C  = CNT_W'(REPEAT_TICKS);

    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] rep_cnt;
    logic             locked;
    logic             counting;
    logic             fire;

    // A hold that began while disabled stays locked out until the button is released.
    assign counting = en && held && !locked && tick;
    assign fire     = counting && ((hold_cnt == HOLD_C - 1'b1) ||
                                   (hold_cnt == HOLD_C && rep_cnt == REP_C - 1'b1));
    assign strobe   = en && (press || fire);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            rep_cnt  <= '0;
            locked   <= 1'b0;
        end else if (!en) begin
            hold_cnt <= '0;
            rep_cnt  <= '0;
            locked   <= held;
        end else if (!held) begin
            hold_cnt <= '0;
            rep_cnt  <= '0;
            locked   <= 1'b0;
        end else if (counting) begin
            if (hold_cnt != HOLD_C)
                hold_cnt <= hold_cnt + 1'b1;
            else if (rep_cnt == REP_C - 1'b1)
                rep_cnt <= '0;
            else
                rep_cnt <= rep_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/watch_set_controller.sv
// rtl/watch_set_controller.sv - mode FSM, idle timeout, blink timer and adjust strobe decode
module watch_set_controller
    import watch_ctrl_pkg::*;
#(
    parameter int CNT_W         = CNT_W_DEF,
    parameter int HOLD_TICKS    = HOLD_TICKS_DEF,
    parameter int REPEAT_TICKS  = REPEAT_TICKS_DEF,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
    parameter int BLINK_TICKS   = BLINK_TICKS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       mode_down,
    input  logic       adj_down,
    input  logic       adj_state,
    output logic [1:0] state_o,
    output logic       run_en,
    output logic       inc_hr,
    output logic       inc_min,
    output logic       clr_sec,
    output logic       blink
);
    localparam int CNT_MAX = (1 << CNT_W);

    if (HOLD_TICKS < 1 || HOLD_TICKS >= CNT_MAX || REPEAT_TICKS < 1 || REPEAT_TICKS >= CNT_MAX ||
        TIMEOUT_TICKS < 1 || TIMEOUT_TICKS >= CNT_MAX || BLINK_TICKS < 1 || BLINK_TICKS >= CNT_MAX)
    begin : g_bad_ticks
        $error("watch_set_controller: tick parameter out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] TO_C = CNT_W'(TIMEOUT_TICKS);
    localparam logic [CNT_W-1:0] BL_C = CNT_W'(BLINK_TICKS);

    mode_e            state;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] blink_cnt;
    logic             rep_en;
    logic             rep_strobe;
    logic             adj_fire;
    logic             timeout;

    assign rep_en   = (state == SET_HR || state == SET_MIN) && !mode_down;
    assign adj_fire = !mode_down && ((state == SET_SEC) ? adj_down : rep_strobe);
    assign timeout  = (state != RUN) && !mode_down && !adj_down && !adj_state &&
                      tick && (idle_cnt == TO_C - 1'b1);
    assign state_o  = state;

    btn_autorepeat #(
        .CNT_W        (CNT_W),
        .HOLD_TICKS   (HOLD_TICKS),
        .REPEAT_TICKS (REPEAT_TICKS)
    ) u_autorepeat (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .en     (rep_en),
        .press  (adj_down),
        .held   (adj_state),
        .strobe (rep_strobe)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            run_en    <= 1'b1;
            inc_hr    <= 1'b0;
            inc_min   <= 1'b0;
            clr_sec   <= 1'b0;
            blink     <= 1'b0;
            idle_cnt  <= '0;
            blink_cnt <= '0;
        end else begin
            inc_hr  <= adj_fire && (state == SET_HR);
            inc_min <= adj_fire && (state == SET_MIN);
            clr_sec <= adj_fire && (state == SET_SEC);

            if (state == RUN || adj_down || adj_state)
                idle_cnt <= '0;
            else if (tick)
                idle_cnt <= idle_cnt + 1'b1;

            if (state != RUN && tick) begin
                if (blink_cnt == BL_C - 1'b1) begin
                    blink_cnt <= '0;
                    blink     <= ~blink;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end

            // Any state entry restarts the idle and blink phases from zero.
            if (mode_down || timeout) begin
                state     <= mode_down ? next_mode(state) : RUN;
                run_en    <= mode_down ? (next_mode(state) == RUN) : 1'b1;
                idle_cnt  <= '0;
                blink_cnt <= '0;
                blink     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_watch_set_controller.sv
// tb/tb_watch_set_controller.sv - directed and randomized checks against a tick-count reference model
module tb_watch_set_controller;
    localparam int HOLD = 4;
    localparam int REP  = 2;
    localparam int TMO  = 20;
    localparam int BLK  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       mode_down = 1'b0;
    logic       adj_down = 1'b0;
    logic       adj_state = 1'b0;
    logic [1:0] state_o;
    logic       run_en, inc_hr, inc_min, clr_sec, blink;

    int n_cmp = 0;
    int n_bad = 0;

    int         m_state, m_idle, m_bt, m_ht;
    bit         m_armed;
    logic [6:0] exp_v;

    watch_set_controller #(
        .CNT_W(14), .HOLD_TICKS(HOLD), .REPEAT_TICKS(REP),
        .TIMEOUT_TICKS(TMO), .BLINK_TICKS(BLK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .mode_down(mode_down),
        .adj_down(adj_down), .adj_state(adj_state), .state_o(state_o),
        .run_en(run_en), .inc_hr(inc_hr), .inc_min(inc_min),
        .clr_sec(clr_sec), .blink(blink)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] obs();
        return {state_o, run_en, inc_hr, inc_min, clr_sec, blink};
    endfunction

    // Reference: modes as integers, hold progress as ticks since the press, blink as ticks since entry.
    task automatic model_step();
        bit fire;
        bit e_hr, e_min, e_sec;
        fire = 0;
        if (!rst_n) begin
            m_state = 0; m_idle = 0; m_bt = 0; m_ht = 0; m_armed = 0;
        end else if (mode_down) begin
            m_state = (m_state + 1) % 4;
            m_idle = 0; m_bt = 0; m_ht = 0; m_armed = 0;
        end else begin
            if (m_state == 1 || m_state == 2) begin
                if (adj_down) begin
                    fire = 1; m_armed = adj_state; m_ht = 0;
                end
                if (!adj_state) begin
                    m_armed = 0; m_ht = 0;
                end else if (m_armed && tick) begin
                    m_ht++;
                    if (m_ht == HOLD || (m_ht > HOLD && (m_ht - HOLD) % REP == 0)) fire = 1;
                end
            end else begin
                m_armed = 0; m_ht = 0;
                if (m_state == 3 && adj_down) fire = 1;
            end
            if (m_state == 0 || adj_down || adj_state) m_idle = 0;
            else if (tick) m_idle++;
            if (m_state != 0 && tick) m_bt++;
        end
        e_hr  = fire && rst_n && !mode_down && m_state == 1;
        e_min = fire && rst_n && !mode_down && m_state == 2;
        e_sec = fire && rst_n && !mode_down && m_state == 3;
        if (m_state != 0 && m_idle == TMO) begin
            m_state = 0; m_idle = 0; m_bt = 0;
        end
        exp_v = {2'(m_state), m_state == 0, e_hr, e_min, e_sec,
                 (m_state != 0) && ((m_bt / BLK) % 2 == 1)};
    endtask

    task automatic cycle(input bit md, input bit ad, input bit as, input bit tk);
        mode_down = md; adj_down = ad; adj_state = as; tick = tk;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle(0, 0, 0, 1);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle(1, 1, 1, 1);
        cycle(0, 0, 0, 1);
        n_cmp++;
        if (obs() !== 7'b00_1_0000) begin
            n_bad++; $display("FAIL reset_state: got %b expected %b", obs(), 7'b00_1_0000);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_mode_cycle();
        logic [1:0] exp_s [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic       exp_r [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0, 1);
            n_cmp++;
            if (state_o !== exp_s[i] || run_en !== exp_r[i]) begin
                n_bad++;
                $display("FAIL mode_cycle[%0d]: got state %0d run_en %b expected state %0d run_en %b",
                         i, state_o, run_en, exp_s[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_single_adj();
        int nstr = 0;
        do_reset();
        cycle(1, 0, 0, 1);
        cycle(0, 1, 0, 1);
        n_cmp++;
        if (inc_hr !== 1'b1 || inc_min !== 1'b0 || clr_sec !== 1'b0) begin
            n_bad++; $display("FAIL single_adj_next: got hr/min/sec %b%b%b expected 100", inc_hr, inc_min, clr_sec);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 0, 1);
            nstr += inc_hr + inc_min + clr_sec;
        end
        n_cmp++;
        if (nstr != 0) begin
            n_bad++; $display("FAIL single_adj_extra: got %0d extra strobes expected 0", nstr);
        end
    endtask

    task automatic test_autorepeat();
        logic [15:0] seen = '0;
        logic [15:0] want = 16'b0001_0101_0101_0010;
        int          other = 0;
        do_reset();
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
        for (int k = 0; k < 12; k++) begin
            cycle(0, k == 0, 1, 1);
            seen[k+1] = inc_min;
            other += inc_hr + clr_sec;
        end
        for (int k = 12; k < 15; k++) begin
            cycle(0, 0, 0, 1);
            seen[k+1] = inc_min;
            other += inc_hr + clr_sec;
        end
        n_cmp++;
        if (seen !== want || other != 0) begin
            n_bad++; $display("FAIL autorepeat_min: got offsets %b (other %0d) expected %b (other 0)", seen, other, want);
        end
    endtask

    task automatic test_sec_hold();
        int nclr = 0, nleft = 0;
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1);
        for (int k = 0; k < 20; k++) begin
            cycle(0, k == 0, 1, 1);
            nclr += clr_sec + inc_hr + inc_min;
            if (state_o !== 2'd3) nleft++;
        end
        cycle(0, 0, 0, 1);
        n_cmp++;
        if (nclr != 1 || nleft != 0 || state_o !== 2'd3) begin
            n_bad++; $display("FAIL sec_hold: got strobes %0d left_sec %0d state %0d expected 1 0 3", nclr, nleft, state_o);
        end
    endtask

    task automatic test_timeout();
        int nstr = 0;
        do_reset();
        cycle(1, 0, 0, 1);
        for (int k = 0; k < 20; k++) begin
            cycle(0, 0, 0, 1);
            nstr += inc_hr + inc_min + clr_sec;
            if (k == 2 || k == 5) begin
                n_cmp++;
                if (blink !== (k == 2)) begin
                    n_bad++; $display("FAIL blink_phase[%0d]: got %b expected %b", k, blink, k == 2);
                end
            end
            if (k == 18) begin
                n_cmp++;
                if (state_o !== 2'd1) begin
                    n_bad++; $display("FAIL timeout_early: got state %0d expected 1", state_o);
                end
            end
        end
        n_cmp++;
        if (state_o !== 2'd0 || run_en !== 1'b1 || nstr != 0) begin
            n_bad++; $display("FAIL timeout_run: got state %0d run_en %b strobes %0d expected 0 1 0", state_o, run_en, nstr);
        end
        cycle(1, 0, 0, 1);
        cycle(1, 1, 0, 1);
        n_cmp++;
        if (state_o !== 2'd2 || inc_hr !== 1'b0 || inc_min !== 1'b0 || clr_sec !== 1'b0) begin
            n_bad++; $display("FAIL mode_wins: got state %0d strobes %b%b%b expected 2 000", state_o, inc_hr, inc_min, clr_sec);
        end
    endtask

    task automatic test_reset_mid_repeat();
        do_reset();
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
        for (int k = 0; k < 7; k++) cycle(0, k == 0, 1, 1);
        rst_n = 1'b0;
        cycle(0, 0, 1, 1);
        n_cmp++;
        if (obs() !== 7'b00_1_0000) begin
            n_bad++; $display("FAIL reset_mid_repeat: got %b expected %b", obs(), 7'b00_1_0000);
        end
        rst_n = 1'b1;
        cycle(0, 0, 1, 1);
        cycle(0, 0, 1, 1);
        n_cmp++;
        if (obs() !== 7'b00_1_0000) begin
            n_bad++; $display("FAIL post_reset_quiet: got %b expected %b", obs(), 7'b00_1_0000);
        end
    endtask

    task automatic test_random();
        bit as = 0, md, ad, tk;
        int nerr = 0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 599) != 0);
            md = ($urandom_range(0, 39) == 0);
            tk = ($urandom_range(0, 3) != 0);
            ad = 0;
            if ($urandom_range(0, 29) == 0) begin
                ad = !as;
                as = !as;
            end
            cycle(md, ad, as, tk);
            n_cmp++;
            if (obs() !== exp_v) begin
                n_bad++;
                if (nerr < 10) $display("FAIL random[%0d]: got %b expected %b", i, obs(), exp_v);
                nerr++;
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        m_state = 0; m_idle = 0; m_bt = 0; m_ht = 0; m_armed = 0; exp_v = 7'b00_1_0000;
        @(negedge clk);
        test_reset();
        test_mode_cycle();
        test_single_adj();
        test_autorepeat();
        test_sec_hold();
        test_timeout();
        test_reset_mid_repeat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
